// File: rtl/jtgng_scan2x.sv
// Line-doubling scan converter: stores each game line in a ping-pong line buffer and replays it twice at cen12.
// Define JTGNG_SCAN2X_SCANLINES_EN to dim every second output line (c - c/4 per channel).
module jtgng_scan2x #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen6,
  input  logic              cen12,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic              HS,
  input  logic              VS,
  output logic [DATA_W-1:0] red_x2,
  output logic [DATA_W-1:0] green_x2,
  output logic [DATA_W-1:0] blue_x2,
  output logic              LHBL_x2,
  output logic              LVBL_x2,
  output logic              HS_x2,
  output logic              VS_x2
);

  localparam int         PIX_W    = 3 * DATA_W;
  localparam logic [9:0] HLEN_DEF = 10'd384;
  localparam logic [8:0] HB_DEF   = 9'd128;
  localparam logic [8:0] NPIX_DEF = 9'd256;
  localparam logic [8:0] HSW_DEF  = 9'd32;

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'd511) ? v : v + 9'd1;
  endfunction

`ifdef JTGNG_SCAN2X_SCANLINES_EN
  function automatic logic [DATA_W-1:0] dim(input logic [DATA_W-1:0] c);
    return c - (c >> 2);
  endfunction
`endif

  logic [PIX_W-1:0] mem [0:511];

  logic       hs_last, bank, hb_found, oline, vs_lat, lvbl_lat;
  logic [1:0] line_cnt;
  logic [8:0] wcnt, waddr, hb_meas, hsw_meas;
  logic [8:0] hbstart, npix, hswidth, ocnt;
  logic [9:0] hlen;

  logic       hs_rise, hb_seen, we, wbank;
  logic [8:0] wcnt_nxt, wa_base;

  always_comb begin
    hs_rise  = cen6 & HS & ~hs_last;
    wcnt_nxt = hs_rise ? 9'd0 : sat_inc9(wcnt);
    wa_base  = hs_rise ? 9'd0 : waddr;
    hb_seen  = hs_rise ? 1'b0 : hb_found;
    wbank    = hs_rise ? ~bank : bank;
    we       = cen6 & LHBL & ~wa_base[8];
  end

  // Input side: measure the line being written, latch its geometry on the next HS rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_last  <= 1'b0;
      wcnt     <= 9'd0;
      waddr    <= 9'd0;
      bank     <= 1'b0;
      hb_meas  <= 9'd0;
      hb_found <= 1'b0;
      hsw_meas <= 9'd0;
      hlen     <= HLEN_DEF;
      hbstart  <= HB_DEF;
      npix     <= NPIX_DEF;
      hswidth  <= HSW_DEF;
      line_cnt <= 2'd0;
      vs_lat   <= 1'b0;
      lvbl_lat <= 1'b0;
    end else if (cen6) begin
      hs_last <= HS;
      wcnt    <= wcnt_nxt;
      waddr   <= we ? wa_base + 9'd1 : wa_base;
      if (hs_rise) begin
        hlen     <= (wcnt == 9'd0) ? HLEN_DEF : {1'b0, wcnt} + 10'd1;
        bank     <= ~bank;
        hbstart  <= hb_meas;
        npix     <= waddr;
        hswidth  <= hsw_meas;
        vs_lat   <= VS;
        lvbl_lat <= LVBL;
        if (line_cnt != 2'd2) line_cnt <= line_cnt + 2'd1;
        hsw_meas <= 9'd1;
      end else if (HS) begin
        hsw_meas <= sat_inc9(hsw_meas);
      end
      if (LHBL && !hb_seen) begin
        hb_meas  <= wcnt_nxt;
        hb_found <= 1'b1;
      end else begin
        hb_found <= hb_seen;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, wa_base[7:0]}] <= {red, green, blue};
  end

  // Output counter: free-runs on hlen, realigned by every input HS rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt  <= 9'd0;
      oline <= 1'b0;
    end else if (cen12) begin
      if (hs_rise) begin
        ocnt  <= 9'd0;
        oline <= 1'b0;
      end else if ({1'b0, ocnt} == hlen - 10'd1) begin
        ocnt  <= 9'd0;
        oline <= ~oline;
      end else begin
        ocnt <= ocnt + 9'd1;
      end
    end
  end

  // Stage p0: decode the current output position
  logic       vld_p0, hs_p0;
  logic [7:0] raddr_p0;

  always_comb begin
    vld_p0   = (line_cnt == 2'd2) && (ocnt >= hbstart) &&
               ({1'b0, ocnt} < {1'b0, hbstart} + {1'b0, npix});
    hs_p0    = ocnt < hswidth;
    raddr_p0 = ocnt[7:0] - hbstart[7:0];
  end

  // Stage p1: line-buffer read from the bank not being written
  logic             vld_p1, hs_p1, vs_p1, lvbl_p1;
  logic [PIX_W-1:0] pix_p1;
`ifdef JTGNG_SCAN2X_SCANLINES_EN
  logic             oline_p1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      lvbl_p1  <= 1'b0;
`ifdef JTGNG_SCAN2X_SCANLINES_EN
      oline_p1 <= 1'b0;
`endif
    end else begin
      vld_p1   <= vld_p0;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_lat;
      lvbl_p1  <= lvbl_lat;
`ifdef JTGNG_SCAN2X_SCANLINES_EN
      oline_p1 <= oline;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pix_p1 <= mem[{~bank, raddr_p0}];
  end

  logic [DATA_W-1:0] r_p1, g_p1, b_p1;

  always_comb begin
    r_p1 = pix_p1[PIX_W-1 -: DATA_W];
    g_p1 = pix_p1[2*DATA_W-1 -: DATA_W];
    b_p1 = pix_p1[DATA_W-1:0];
`ifdef JTGNG_SCAN2X_SCANLINES_EN
    if (oline_p1) begin
      r_p1 = dim(r_p1);
      g_p1 = dim(g_p1);
      b_p1 = dim(b_p1);
    end
`endif
  end

  // Stage p2: output registers, colour blanked outside the active window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_x2   <= '0;
      green_x2 <= '0;
      blue_x2  <= '0;
      LHBL_x2  <= 1'b0;
      HS_x2    <= 1'b0;
      VS_x2    <= 1'b0;
      LVBL_x2  <= 1'b0;
    end else begin
      red_x2   <= vld_p1 ? r_p1 : '0;
      green_x2 <= vld_p1 ? g_p1 : '0;
      blue_x2  <= vld_p1 ? b_p1 : '0;
      LHBL_x2  <= vld_p1;
      HS_x2    <= hs_p1;
      VS_x2    <= vs_p1;
      LVBL_x2  <= lvbl_p1;
    end
  end

endmodule

// File: tb/tb_jtgng_scan2x.sv
// Randomised bench for jtgng_scan2x: a line-level reference model feeds a scoreboard of expected output ticks.
module tb_jtgng_scan2x;

  logic       clk = 1'b0, rst_n = 1'b0, cen6 = 1'b0, cen12 = 1'b0;
  logic [3:0] red = 4'd0, green = 4'd0, blue = 4'd0;
  logic       LHBL = 1'b0, LVBL = 1'b1, HS = 1'b0, VS = 1'b0;
  logic [3:0] red_x2, green_x2, blue_x2;
  logic       LHBL_x2, LVBL_x2, HS_x2, VS_x2;

  int vectors = 0, miscompares = 0;
  logic [15:0] exp_q[$];

  jtgng_scan2x dut (
    .clk(clk), .rst_n(rst_n), .cen6(cen6), .cen12(cen12),
    .red(red), .green(green), .blue(blue),
    .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
    .red_x2(red_x2), .green_x2(green_x2), .blue_x2(blue_x2),
    .LHBL_x2(LHBL_x2), .LVBL_x2(LVBL_x2), .HS_x2(HS_x2), .VS_x2(VS_x2)
  );

  initial forever #5 clk = ~clk;

  // Reference model: the line being received and the geometry/pixels of the last finished line
  int          idx, k, rises, hlen_m, hb_m, np_m, hsw_m, cur_hb, cur_hsw;
  logic        prev_hs, vs_m, lvbl_m;
  logic [11:0] cur_pix[$];
  logic [11:0] line_pix [0:255];

  task automatic model_reset();
    idx = 0; k = 0; rises = 0;
    hlen_m = 384; hb_m = 128; np_m = 256; hsw_m = 32;
    cur_hb = -1; cur_hsw = 0; prev_hs = 1'b0;
    cur_pix.delete();
    vs_m = 1'b0; lvbl_m = 1'b0;
  endtask

  task automatic model_cen6(input logic hs, input logic lh, input logic [11:0] pix,
                            input logic vs, input logic lvbl, output logic rise);
    rise = hs && !prev_hs;
    prev_hs = hs;
    if (rise) begin
      hlen_m  = (idx + 1 < 2) ? 384 : idx + 1;
      hb_m    = (cur_hb < 0) ? 0 : cur_hb;
      np_m    = cur_pix.size();
      hsw_m   = cur_hsw;
      for (int i = 0; i < np_m; i++) line_pix[i] = cur_pix[i];
      vs_m    = vs;
      lvbl_m  = lvbl;
      rises++;
      idx = 0; cur_hb = -1; cur_hsw = 0; k = 0;
      cur_pix.delete();
    end else if (idx < 511) begin
      idx++;
    end
    if (hs && cur_hsw < 511) cur_hsw++;
    if (lh) begin
      if (cur_hb < 0) cur_hb = idx;
      if (cur_pix.size() < 256) cur_pix.push_back(pix);
    end
  endtask

`ifdef JTGNG_SCAN2X_SCANLINES_EN
  function automatic logic [3:0] dimc(input logic [3:0] c);
    int v;
    v = int'(c) - int'(c) / 4;
    return 4'(v);
  endfunction
`endif

  task automatic model_cen12(input logic rise);
    int pos;
    logic lh, hx;
    logic [11:0] rgb;
    if (!rise) k++;
    pos = k % hlen_m;
    lh  = (rises >= 2) && (pos >= hb_m) && (pos < hb_m + np_m);
    hx  = pos < hsw_m;
    rgb = 12'h000;
    if (lh) rgb = line_pix[pos - hb_m];
`ifdef JTGNG_SCAN2X_SCANLINES_EN
    if (((k / hlen_m) % 2) == 1) rgb = {dimc(rgb[11:8]), dimc(rgb[7:4]), dimc(rgb[3:0])};
`endif
    exp_q.push_back({lh, hx, vs_m, lvbl_m, rgb});
  endtask

  // One cen6 pixel period = four clk: cen6 on phase 0, cen12 on phases 0 and 2
  task automatic tick(input logic hs, input logic lh, input logic [11:0] pix,
                      input logic vs, input logic lvbl);
    logic rise;
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk);
      cen6  = (ph == 0);
      cen12 = (ph == 0) || (ph == 2);
      if (ph == 0) begin
        HS = hs; LHBL = lh; {red, green, blue} = pix; VS = vs; LVBL = lvbl;
        model_cen6(hs, lh, pix, vs, lvbl, rise);
        model_cen12(rise);
      end else if (ph == 2) begin
        model_cen12(1'b0);
      end
    end
  endtask

  // mode 0: pixel n coloured n, mode 1: random colour, mode 2: constant 0xFFF
  task automatic line(input int len, input int hsw, input int lbs, input int lbl, input int mode);
    logic vs, lvbl;
    logic [11:0] pix;
    vs   = 1'($urandom_range(0, 1));
    lvbl = 1'($urandom_range(0, 1));
    for (int t = 0; t < len; t++) begin
      case (mode)
        0:       pix = 12'(t - lbs);
        1:       pix = 12'($urandom);
        default: pix = 12'hFFF;
      endcase
      tick(t < hsw, (t >= lbs) && (t < lbs + lbl), pix, vs, lvbl);
    end
  endtask

  task automatic check_zero(input string name);
    logic [15:0] got;
    got = {LHBL_x2, HS_x2, VS_x2, LVBL_x2, red_x2, green_x2, blue_x2};
    vectors++;
    if (got !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s: outputs=%h required=0000", name, got);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk); cen6 = 1'b0; cen12 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_assert");
    exp_q.delete();
    model_reset();
    repeat (4) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
  endtask

  // Monitor: each cen12 tick is presented on the outputs two clk later
  logic        m_d1 = 1'b0, m_d2 = 1'b0, m_chk;
  logic [15:0] m_exp, m_got;

  initial forever begin
    @(posedge clk);
    m_chk = m_d2;
    m_d2  = m_d1;
    m_d1  = cen12 & rst_n;
    if (!rst_n) begin
      m_chk = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
    end
    if (m_chk) begin
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: output tick with no expected entry");
      end else begin
        m_exp = exp_q.pop_front();
        m_got = {LHBL_x2, HS_x2, VS_x2, LVBL_x2, red_x2, green_x2, blue_x2};
        if (m_got !== m_exp) begin
          miscompares++;
          $display("FAIL pixel_%0d: got lhbl=%b hs=%b vs=%b lvbl=%b rgb=%h, required lhbl=%b hs=%b vs=%b lvbl=%b rgb=%h",
                   vectors, m_got[15], m_got[14], m_got[13], m_got[12], m_got[11:0],
                   m_exp[15], m_exp[14], m_exp[13], m_exp[12], m_exp[11:0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_initial");
    rst_n = 1'b1;

    repeat (800) tick(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);

    repeat (3) line(384, 32, 128, 256, 0);
    repeat (3) line(384, 32, 128, 256, 1);

    line(384, 32, 80, 300, 1);
    line(384, 32, 128, 256, 1);

    repeat (3) line(320, 24, 64, 240, 1);
    line(384, 32, 128, 256, 1);

    repeat (3) line(384, 32, 128, 256, 2);

    line(200, 32, 128, 256, 1);
    reset_pulse();
    repeat (4) line(384, 32, 128, 256, 1);

    repeat (4) @(negedge clk);
    cen6 = 1'b0; cen12 = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
